// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN layer sequencers.
// Covers the conv-1 output map and the pooling-1 output map.
package cnn_pkg;

    localparam int CONV1_DIM      = 24;
    localparam int P1_DIM         = 12;
    localparam int P1_HALF        = 72;
    localparam int CONV1_HALF_OFS = 288;
    localparam int CONV1_AW       = 10;
    localparam int P1_AW          = 8;

    typedef enum logic [1:0] {
        P1_IDLE,
        P1_FETCH,
        P1_DONE
    } p1_state_t;

endpackage

// File: rtl/p1_win_addr.sv
// Window walker for pooling-1 half 0.
// Contains the k/c/r counters, the next conv-1 read address and the output window index.
import cnn_pkg::*;

module p1_win_addr (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_advance,
    input  logic                i_wr,
    output logic [1:0]          o_k,
    output logic                o_last,
    output logic [CONV1_AW-1:0] o_rd_addr,
    output logic [P1_AW-1:0]    o_wr_addr
);

    logic [1:0]       r_k;
    logic [3:0]       r_c;
    logic [2:0]       r_r;
    logic [P1_AW-1:0] r_w;
    logic [1:0]       w_kn;
    logic [3:0]       w_cn;
    logic [2:0]       w_rn;

    // o_rd_addr is the address for the counter values that take effect at the next edge,
    // so the top can register it alongside the counters.
    always_comb begin
        w_kn = r_k;
        w_cn = r_c;
        w_rn = r_r;
        if (i_clear) begin
            w_kn = 2'd0;
            w_cn = 4'd0;
            w_rn = 3'd0;
        end else if (i_advance) begin
            w_kn = r_k + 2'd1;
            if (r_k == 2'd3) begin
                if (r_c == 4'(P1_DIM - 1)) begin
                    w_cn = 4'd0;
                    w_rn = r_r + 3'd1;
                end else begin
                    w_cn = r_c + 4'd1;
                end
            end
        end
    end

    assign o_rd_addr = (CONV1_AW'({w_rn, 1'b0}) + CONV1_AW'(w_kn[1])) * CONV1_AW'(CONV1_DIM)
                     + CONV1_AW'({w_cn, 1'b0}) + CONV1_AW'(w_kn[0]);
    assign o_k       = r_k;
    assign o_wr_addr = r_w;
    assign o_last    = (r_k == 2'd3) && (r_c == 4'(P1_DIM - 1)) && (r_r == 3'(P1_DIM / 2 - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k <= 2'd0;
            r_c <= 4'd0;
            r_r <= 3'd0;
            r_w <= '0;
        end else begin
            r_k <= w_kn;
            r_c <= w_cn;
            r_r <= w_rn;
            if (i_clear)
                r_w <= '0;
            else if (i_wr)
                r_w <= r_w + 1'b1;
        end
    end

endmodule

// File: rtl/p1_pool_ctrl.sv
// Pooling-1 sequencer that computes the 2x2 signed max over the conv-1 map.
// Both RAM ports run in parallel: half 0 covers output rows 0-5 and half 1 covers rows 6-11.
import cnn_pkg::*;

module p1_pool_ctrl #(
    parameter int DATA_W  = 16,
    parameter int IN_DIM  = 24,
    parameter int OUT_DIM = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    output logic [CONV1_AW-1:0] o_in_rd_addr0,
    output logic [CONV1_AW-1:0] o_in_rd_addr1,
    input  logic [DATA_W-1:0]   i_in_rd_data0,
    input  logic [DATA_W-1:0]   i_in_rd_data1,
    output logic                o_out_we,
    output logic [P1_AW-1:0]    o_out_addr0,
    output logic [P1_AW-1:0]    o_out_addr1,
    output logic [DATA_W-1:0]   o_out_wdata0,
    output logic [DATA_W-1:0]   o_out_wdata1,
    output logic                o_busy,
    output logic                o_done
);

    localparam int IN_OFS  = IN_DIM * IN_DIM / 2;
    localparam int OUT_OFS = OUT_DIM * OUT_DIM / 2;

    p1_state_t           r_state;
    logic                r_rd_valid;
    logic                r_vd;
    logic [1:0]          r_kd;
    logic [DATA_W-1:0]   r_acc0;
    logic [DATA_W-1:0]   r_acc1;
    logic [DATA_W-1:0]   w_max0;
    logic [DATA_W-1:0]   w_max1;
    logic                w_clear;
    logic                w_advance;
    logic                w_wr;
    logic                w_last;
    logic [1:0]          w_k;
    logic [CONV1_AW-1:0] w_rd_addr;
    logic [P1_AW-1:0]    w_wr_addr;

    assign w_clear   = i_start && (r_state == P1_IDLE || r_state == P1_DONE);
    assign w_advance = (r_state == P1_FETCH) && r_rd_valid && !w_last;
    assign w_wr      = r_vd && (r_kd == 2'd3);

    assign w_max0 = (r_kd == 2'd0 || $signed(i_in_rd_data0) > $signed(r_acc0)) ? i_in_rd_data0 : r_acc0;
    assign w_max1 = (r_kd == 2'd0 || $signed(i_in_rd_data1) > $signed(r_acc1)) ? i_in_rd_data1 : r_acc1;

    p1_win_addr u_win_addr (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .i_wr      (w_wr),
        .o_k       (w_k),
        .o_last    (w_last),
        .o_rd_addr (w_rd_addr),
        .o_wr_addr (w_wr_addr)
    );

    // r_vd/r_kd trail the presented read by one cycle, which lines them up with the returning RAM data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= P1_IDLE;
            r_rd_valid    <= 1'b0;
            r_vd          <= 1'b0;
            r_kd          <= 2'd0;
            r_acc0        <= '0;
            r_acc1        <= '0;
            o_in_rd_addr0 <= '0;
            o_in_rd_addr1 <= CONV1_AW'(IN_OFS);
            o_out_we      <= 1'b0;
            o_out_addr0   <= '0;
            o_out_addr1   <= P1_AW'(OUT_OFS);
            o_out_wdata0  <= '0;
            o_out_wdata1  <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            o_in_rd_addr0 <= w_rd_addr;
            o_in_rd_addr1 <= w_rd_addr + CONV1_AW'(IN_OFS);
            r_vd          <= r_rd_valid;
            r_kd          <= w_k;
            o_out_we      <= 1'b0;

            if (r_vd) begin
                r_acc0 <= w_max0;
                r_acc1 <= w_max1;
                if (r_kd == 2'd3) begin
                    o_out_we     <= 1'b1;
                    o_out_wdata0 <= w_max0;
                    o_out_wdata1 <= w_max1;
                    o_out_addr0  <= w_wr_addr;
                    o_out_addr1  <= w_wr_addr + P1_AW'(OUT_OFS);
                end
            end

            case (r_state)
                P1_IDLE, P1_DONE: begin
                    if (i_start) begin
                        r_state    <= P1_FETCH;
                        r_rd_valid <= 1'b1;
                        o_busy     <= 1'b1;
                        o_done     <= 1'b0;
                    end
                end
                P1_FETCH: begin
                    if (r_rd_valid && w_last)
                        r_rd_valid <= 1'b0;
                    // The final write has just been presented once no reads remain in flight.
                    if (!r_rd_valid && !r_vd && o_out_we) begin
                        r_state <= P1_DONE;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end
                end
                default: r_state <= P1_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p1_pool_ctrl.sv
// Self-checking bench for p1_pool_ctrl: a RAM model plus a reference pooling model.
// Covers directed and randomized passes, checking both the timing and the data.
module tb_p1_pool_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [9:0]  o_in_rd_addr0;
    logic [9:0]  o_in_rd_addr1;
    logic [15:0] i_in_rd_data0;
    logic [15:0] i_in_rd_data1;
    logic        o_out_we;
    logic [7:0]  o_out_addr0;
    logic [7:0]  o_out_addr1;
    logic [15:0] o_out_wdata0;
    logic [15:0] o_out_wdata1;
    logic        o_busy;
    logic        o_done;

    logic [15:0] mem [576];
    logic [15:0] expOut [144];
    int          testsRun = 0;
    int          testsFailed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        i_in_rd_data0 <= mem[o_in_rd_addr0];
        i_in_rd_data1 <= mem[o_in_rd_addr1];
    end

    p1_pool_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .o_in_rd_addr0 (o_in_rd_addr0),
        .o_in_rd_addr1 (o_in_rd_addr1),
        .i_in_rd_data0 (i_in_rd_data0),
        .i_in_rd_data1 (i_in_rd_data1),
        .o_out_we      (o_out_we),
        .o_out_addr0   (o_out_addr0),
        .o_out_addr1   (o_out_addr1),
        .o_out_wdata0  (o_out_wdata0),
        .o_out_wdata1  (o_out_wdata1),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference 2x2 signed max pooling over the whole 24x24 image.
    task automatic computeModel();
        for (int orow = 0; orow < 12; orow++) begin
            for (int ocol = 0; ocol < 12; ocol++) begin
                logic [15:0] best;
                best = mem[(2 * orow) * 24 + 2 * ocol];
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        if ($signed(mem[(2 * orow + dy) * 24 + 2 * ocol + dx]) > $signed(best))
                            best = mem[(2 * orow + dy) * 24 + 2 * ocol + dx];
                expOut[orow * 12 + ocol] = best;
            end
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_we", o_out_we, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_out_addr0", o_out_addr0, 0);
        checkOutput("rst_out_addr1", o_out_addr1, 72);
        checkOutput("rst_in_addr0", o_in_rd_addr0, 0);
        checkOutput("rst_in_addr1", o_in_rd_addr1, 288);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetState();
        reset = 1'b0;
    endtask

    // Runs one pass; glitchA/glitchB are edges at which start is re-pulsed; abortAt resets after that many writes.
    task automatic applyStimulus(input int glitchA, input int glitchB, input int abortAt, input bit ramp, input bit signedChk);
        int wi;
        int w;
        int k;
        int expAddr;
        int stray;
        wi = 0;
        @(negedge clk);
        i_start = 1'b1;
        for (int e = 0; e <= 295; e++) begin
            @(negedge clk);
            i_start = (e + 1 == glitchA) || (e + 1 == glitchB);
            if (e < 288) begin
                w = e / 4;
                k = e % 4;
                expAddr = (2 * (w / 12) + k / 2) * 24 + 2 * (w % 12) + k % 2;
                checkOutput("rd_addr0", o_in_rd_addr0, expAddr);
                checkOutput("rd_addr1", o_in_rd_addr1, expAddr + 288);
            end
            if (e == 0) begin
                checkOutput("start_done_low", o_done, 0);
                checkOutput("start_busy_high", o_busy, 1);
            end
            if (e == 289) begin
                checkOutput("pre_done_low", o_done, 0);
                checkOutput("pre_busy_high", o_busy, 1);
            end
            if (e == 290) begin
                checkOutput("done_rise", o_done, 1);
                checkOutput("busy_fall", o_busy, 0);
            end
            if (o_out_we) begin
                checkOutput("wr_time", e, 5 + 4 * wi);
                checkOutput("wr_addr0", o_out_addr0, wi);
                checkOutput("wr_addr1", o_out_addr1, wi + 72);
                if (wi < 72) begin
                    checkOutput("wr_data0", o_out_wdata0, expOut[wi]);
                    checkOutput("wr_data1", o_out_wdata1, expOut[wi + 72]);
                end
                if (ramp && wi == 0) begin
                    checkOutput("ramp_w0_d0", o_out_wdata0, 25);
                    checkOutput("ramp_w0_d1", o_out_wdata1, 313);
                end
                if (ramp && wi == 71) begin
                    checkOutput("ramp_w71_d0", o_out_wdata0, 287);
                    checkOutput("ramp_w71_d1", o_out_wdata1, 575);
                end
                if (signedChk && wi == 0) begin
                    checkOutput("smax_d0", o_out_wdata0, 16'hFFFD);
                    checkOutput("smax_d1", o_out_wdata1, 16'h7FFF);
                end
                wi++;
                if (abortAt >= 0 && wi == abortAt) begin
                    applyReset();
                    stray = 0;
                    for (int j = 0; j < 40; j++) begin
                        @(negedge clk);
                        if (o_out_we) stray++;
                    end
                    checkOutput("abort_no_writes", stray, 0);
                    checkOutput("abort_done_low", o_done, 0);
                    return;
                end
            end
        end
        checkOutput("write_count", wi, 72);
        checkOutput("done_held", o_done, 1);
    endtask

    initial begin
        reset = 1'b1;
        i_start = 1'b0;
        for (int a = 0; a < 576; a++) mem[a] = '0;
        @(negedge clk);
        applyReset();

        for (int a = 0; a < 576; a++) mem[a] = 16'(a);
        computeModel();
        applyStimulus(-1, -1, -1, 1'b1, 1'b0);

        mem[0]   = 16'hFFFB;
        mem[1]   = 16'hFFFD;
        mem[24]  = 16'hFFF9;
        mem[25]  = 16'hFF9C;
        mem[288] = 16'h7FFF;
        mem[289] = 16'h8000;
        mem[312] = 16'h0000;
        mem[313] = 16'h0001;
        computeModel();
        applyStimulus(-1, -1, -1, 1'b0, 1'b1);

        for (int a = 0; a < 576; a++)
            mem[a] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
        computeModel();
        applyStimulus(10, 100, -1, 1'b0, 1'b0);

        applyStimulus(-1, -1, 30, 1'b0, 1'b0);

        for (int a = 0; a < 576; a++) mem[a] = 16'($urandom);
        computeModel();
        applyStimulus(-1, -1, -1, 1'b0, 1'b0);

        @(negedge clk);
        applyReset();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
